// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator.
// Holds the fetch PC, drives the synchronous-read instruction memory address,
// tags the returned instruction with its PC and a valid bit, and squashes the
// in-flight wrong-path instruction whenever the IF control logic redirects.
//
// Build option: define FETCH_BHT_EN to add a small 2-bit branch history table
// that predicts conditional branches (B-type) at fetch time. Without it the
// sequential path is always pc+4 and f_pred_taken is tied low.
module fetch_pc_gen #(
    parameter logic [31:0] RESET_PC    = 32'h4000_0000,
    parameter int          BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [2:0]  pc_select,
    input  logic [31:0] jal_target,
    input  logic [31:0] redirect_target,
    input  logic [31:0] f_instruction,
    input  logic        bht_update,
    input  logic [31:0] bht_update_pc,
    input  logic        bht_update_taken,
    output logic [31:0] imem_addr,
    output logic [31:0] f_pc,
    output logic        f_valid,
    output logic        f_pred_taken
);

    // RESET is the cycle in which rst is high; BOOT is the first cycle after
    // it, spent waiting for the RESET_PC read to come back; RUN is normal fetch.
    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_BOOT  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam logic [2:0] SEL_RESTART  = 3'd0;
    localparam logic [2:0] SEL_JAL      = 3'd1;
    localparam logic [2:0] SEL_REDIRECT = 3'd3;

    state_e      state_q;
    state_e      state_d;
    state_e      state_s;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        valid_q;
    logic        valid_d;

    logic        redirect_s;
    logic        pred_s;
    logic [31:0] seq_next_s;
    logic [31:0] raw_addr_s;
    logic        f_valid_s;

    // rst takes precedence over whatever state is registered.
    assign state_s = rst ? ST_RESET : state_q;

    // Restart, jal and jalr/mispredict all discard the instruction in flight.
    assign redirect_s = (pc_select == SEL_RESTART) ||
                        (pc_select == SEL_JAL)     ||
                        (pc_select == SEL_REDIRECT);

`ifdef FETCH_BHT_EN
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    // Saturating 2-bit counter step toward the resolved outcome.
    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            nxt = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return nxt;
    endfunction

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [IDX_W-1:0] lookup_idx_s;
    logic [IDX_W-1:0] update_idx_s;
    logic [31:0]      b_imm_s;
    logic             is_branch_s;
    logic             unused_bht_s;

    assign lookup_idx_s = pc_q[IDX_W+1:2];
    assign update_idx_s = bht_update_pc[IDX_W+1:2];
    assign is_branch_s  = (f_instruction[6:2] == 5'b11000);
    assign b_imm_s      = {{20{f_instruction[31]}}, f_instruction[7],
                           f_instruction[30:25], f_instruction[11:8], 1'b0};

    // Lookup reads the registered table, so a same-cycle update at the same
    // index is not yet visible to the prediction.
    assign pred_s     = valid_q && is_branch_s && bht_q[lookup_idx_s][1];
    assign seq_next_s = pred_s ? (pc_q + b_imm_s) : (pc_q + 32'd4);

    assign unused_bht_s = ^{f_instruction[24:12], f_instruction[1:0],
                            bht_update_pc[31:IDX_W+2], bht_update_pc[1:0]};

    // Counter table: weakly not-taken after reset, trained by resolved branches.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (bht_update) begin
            bht_q[update_idx_s] <= sat_step(bht_q[update_idx_s], bht_update_taken);
        end else begin
            bht_q[update_idx_s] <= bht_q[update_idx_s];
        end
    end
`else
    logic        unused_bht_s;
    logic [31:0] unused_bht_cfg_s;

    assign pred_s           = 1'b0;
    assign seq_next_s       = pc_q + 32'd4;
    assign unused_bht_s     = ^{f_instruction, bht_update, bht_update_pc, bht_update_taken};
    assign unused_bht_cfg_s = BHT_ENTRIES;
`endif

    // Next fetch address, next PC/valid and the squash decision per state.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        raw_addr_s = RESET_PC;
        f_valid_s  = 1'b0;
        case (state_s)
            ST_RESET: begin
                raw_addr_s = RESET_PC;
                pc_d       = RESET_PC - 32'd4;
                valid_d    = 1'b0;
                state_d    = ST_BOOT;
            end
            ST_BOOT: begin
                raw_addr_s = RESET_PC;
                pc_d       = RESET_PC;
                valid_d    = 1'b1;
                state_d    = ST_RUN;
            end
            ST_RUN: begin
                case (pc_select)
                    SEL_RESTART:  raw_addr_s = RESET_PC;
                    SEL_JAL:      raw_addr_s = jal_target;
                    SEL_REDIRECT: raw_addr_s = redirect_target;
                    default: begin
                        if (stall) begin
                            raw_addr_s = pc_q;
                        end else begin
                            raw_addr_s = seq_next_s;
                        end
                    end
                endcase
                f_valid_s = valid_q && !redirect_s;
                if (redirect_s || !stall) begin
                    pc_d    = {raw_addr_s[31:2], 2'b00};
                    valid_d = 1'b1;
                end else begin
                    pc_d    = pc_q;
                    valid_d = valid_q;
                end
                state_d = ST_RUN;
            end
            default: begin
                raw_addr_s = RESET_PC;
                pc_d       = RESET_PC - 32'd4;
                valid_d    = 1'b0;
                state_d    = ST_BOOT;
            end
        endcase
    end

    assign imem_addr    = {raw_addr_s[31:2], 2'b00};
    assign f_pc         = pc_q;
    assign f_valid      = f_valid_s;
    assign f_pred_taken = pred_s && f_valid_s;

    // Fetch PC, valid flag and FSM state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC - 32'd4;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the fetch rules.
module tb_fetch_pc_gen;

    localparam logic [31:0] RESET_PC = 32'h4000_0000;
    localparam int          BHT_N    = 16;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [2:0]  pc_select;
    logic [31:0] jal_target;
    logic [31:0] redirect_target;
    logic [31:0] f_instruction;
    logic        bht_update;
    logic [31:0] bht_update_pc;
    logic        bht_update_taken;
    logic [31:0] imem_addr;
    logic [31:0] f_pc;
    logic        f_valid;
    logic        f_pred_taken;

    int checks = 0;
    int errors = 0;

    // model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_boot;
    logic        m_known = 1'b0;
    int          m_bht [BHT_N];

    fetch_pc_gen #(.RESET_PC(RESET_PC), .BHT_ENTRIES(BHT_N)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .pc_select        (pc_select),
        .jal_target       (jal_target),
        .redirect_target  (redirect_target),
        .f_instruction    (f_instruction),
        .bht_update       (bht_update),
        .bht_update_pc    (bht_update_pc),
        .bht_update_taken (bht_update_taken),
        .imem_addr        (imem_addr),
        .f_pc             (f_pc),
        .f_valid          (f_valid),
        .f_pred_taken     (f_pred_taken)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int bht_idx(input logic [31:0] pc);
        return int'((pc >> 2) % BHT_N);
    endfunction

    // One cycle: drive inputs mid-cycle, check outputs against the model, advance the model.
    task automatic step(input logic r, input logic st, input logic [2:0] sel,
                        input logic [31:0] jt, input logic [31:0] rt, input logic [31:0] ins,
                        input logic up, input logic [31:0] up_pc, input logic up_t);
        logic [31:0] e_addr;
        logic [31:0] tgt;
        logic [31:0] bimm;
        logic        e_valid;
        logic        e_pred;
        logic        pred;
        logic        redirect;
        @(negedge clk);
        rst = r; stall = st; pc_select = sel; jal_target = jt; redirect_target = rt;
        f_instruction = ins; bht_update = up; bht_update_pc = up_pc; bht_update_taken = up_t;
        #1;
        if (r) begin
            e_addr = RESET_PC; e_valid = 1'b0; e_pred = 1'b0;
        end else if (m_boot) begin
            e_addr = RESET_PC; e_valid = 1'b0; e_pred = 1'b0;
        end else begin
            redirect = (sel == 3'd0) || (sel == 3'd1) || (sel == 3'd3);
`ifdef FETCH_BHT_EN
            pred = m_valid && (ins[6:0] == 7'b1100011 || ins[6:2] == 5'b11000) && (m_bht[bht_idx(m_pc)] >= 2);
`else
            pred = 1'b0;
`endif
            bimm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            if (sel == 3'd0)       tgt = RESET_PC;
            else if (sel == 3'd1)  tgt = jt;
            else if (sel == 3'd3)  tgt = rt;
            else if (st)           tgt = m_pc;
            else if (pred)         tgt = m_pc + bimm;
            else                   tgt = m_pc + 32'd4;
            e_addr  = tgt & 32'hFFFF_FFFC;
            e_valid = m_valid && !redirect;
            e_pred  = pred && e_valid;
        end
        check_eq("imem_addr", imem_addr, e_addr);
        if (m_known) check_eq("f_pc", f_pc, m_pc);
        check_eq("f_valid", {31'd0, f_valid}, {31'd0, e_valid});
        check_eq("f_pred_taken", {31'd0, f_pred_taken}, {31'd0, e_pred});
        // advance model
        if (r) begin
            m_pc = RESET_PC - 32'd4; m_valid = 1'b0; m_boot = 1'b1;
            for (int i = 0; i < BHT_N; i++) m_bht[i] = 1;
        end else begin
            if (m_boot) begin
                m_pc = RESET_PC; m_valid = 1'b1; m_boot = 1'b0;
            end else if (redirect || !st) begin
                m_pc = e_addr; m_valid = 1'b1;
            end
            if (up) begin
                if (up_t) m_bht[bht_idx(up_pc)] = (m_bht[bht_idx(up_pc)] == 3) ? 3 : m_bht[bht_idx(up_pc)] + 1;
                else      m_bht[bht_idx(up_pc)] = (m_bht[bht_idx(up_pc)] == 0) ? 0 : m_bht[bht_idx(up_pc)] - 1;
            end
        end
        m_known = 1'b1;
    endtask

    // simple sequential cycle with a non-branch instruction
    task automatic seq_step(input logic st);
        step(1'b0, st, 3'd2, 32'd0, 32'd0, NOP, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins;
        logic [2:0]  sel;
        int          r;
        rst = 1'b1; stall = 1'b0; pc_select = 3'd2; jal_target = 32'd0; redirect_target = 32'd0;
        f_instruction = NOP; bht_update = 1'b0; bht_update_pc = 32'd0; bht_update_taken = 1'b0;
        m_pc = RESET_PC - 32'd4; m_valid = 1'b0; m_boot = 1'b1;
        for (int i = 0; i < BHT_N; i++) m_bht[i] = 1;

        // 1: reset for 3 cycles, boot, then sequential fetch
        repeat (3) step(1'b1, 1'b0, 3'd2, 32'd0, 32'd0, NOP, 1'b0, 32'd0, 1'b0);
        seq_step(1'b0);
        check_eq("boot_addr", imem_addr, 32'h4000_0000);
        check_eq("boot_valid", {31'd0, f_valid}, 32'd0);
        check_eq("boot_fpc", f_pc, 32'h3FFF_FFFC);
        seq_step(1'b0);
        check_eq("first_fpc", f_pc, 32'h4000_0000);
        check_eq("first_valid", {31'd0, f_valid}, 32'd1);
        seq_step(1'b0);
        check_eq("second_fpc", f_pc, 32'h4000_0004);

        // 2: stall two cycles at 0x40000008
        seq_step(1'b1);
        check_eq("stall_addr", imem_addr, 32'h4000_0008);
        check_eq("stall_fpc", f_pc, 32'h4000_0008);
        seq_step(1'b1);
        check_eq("stall2_fpc", f_pc, 32'h4000_0008);
        check_eq("stall2_valid", {31'd0, f_valid}, 32'd1);
        seq_step(1'b0);
        seq_step(1'b0);
        check_eq("post_stall_fpc", f_pc, 32'h4000_000C);

        // 3: jal with stall in the same cycle
        step(1'b0, 1'b1, 3'd1, 32'h4000_0100, 32'd0, NOP, 1'b0, 32'd0, 1'b0);
        check_eq("jal_addr", imem_addr, 32'h4000_0100);
        check_eq("jal_squash", {31'd0, f_valid}, 32'd0);
        seq_step(1'b0);
        check_eq("jal_fpc", f_pc, 32'h4000_0100);
        check_eq("jal_valid", {31'd0, f_valid}, 32'd1);

        // 4: redirect to an unaligned target
        step(1'b0, 1'b0, 3'd3, 32'd0, 32'h4000_0203, NOP, 1'b0, 32'd0, 1'b0);
        check_eq("redir_addr", imem_addr, 32'h4000_0200);
        seq_step(1'b0);
        check_eq("redir_fpc", f_pc, 32'h4000_0200);

        // 5: reset mid-stream at 0x40000040
        step(1'b0, 1'b0, 3'd1, 32'h4000_0040, 32'd0, NOP, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 3'd2, 32'd0, 32'd0, NOP, 1'b0, 32'd0, 1'b0);
        check_eq("midrst_fpc", f_pc, 32'h4000_0040);
        seq_step(1'b0);
        check_eq("midrst_valid", {31'd0, f_valid}, 32'd0);
        check_eq("midrst_addr", imem_addr, 32'h4000_0000);
        seq_step(1'b0);
        check_eq("midrst_refetch", f_pc, 32'h4000_0000);

        // 6: train 0x40000010 taken, then fetch BEQ +16 there
        step(1'b0, 1'b0, 3'd1, 32'h4000_0010, 32'd0, NOP, 1'b1, 32'h4000_0010, 1'b1);
        step(1'b0, 1'b0, 3'd2, 32'd0, 32'd0, 32'h0000_0863, 1'b0, 32'd0, 1'b0);
        check_eq("bht_fpc", f_pc, 32'h4000_0010);
`ifdef FETCH_BHT_EN
        check_eq("bht_addr", imem_addr, 32'h4000_0020);
        check_eq("bht_pred", {31'd0, f_pred_taken}, 32'd1);
`else
        check_eq("bht_addr", imem_addr, 32'h4000_0014);
        check_eq("bht_pred", {31'd0, f_pred_taken}, 32'd0);
`endif

        // wrap 0xFFFFFFFC -> 0
        step(1'b0, 1'b0, 3'd1, 32'hFFFF_FFFC, 32'd0, NOP, 1'b0, 32'd0, 1'b0);
        seq_step(1'b0);
        check_eq("wrap_addr", imem_addr, 32'h0000_0000);
        seq_step(1'b0);
        check_eq("wrap_fpc", f_pc, 32'h0000_0000);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 15));
            if (r < 9)        sel = 3'd2;
            else if (r < 11)  sel = 3'(4 + $urandom_range(0, 3));
            else if (r == 11) sel = 3'd0;
            else if (r < 14)  sel = 3'd1;
            else              sel = 3'd3;
            ins = $urandom;
            if ($urandom_range(0, 1) == 1) ins[6:0] = 7'b1100011;
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0), sel,
                 RESET_PC + ($urandom & 32'h0000_0FFF), $urandom, ins,
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 3) == 0) ? m_pc : (RESET_PC + ($urandom & 32'h0000_00FC)),
                 ($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
